// File: rtl/sap_pkg.sv
// Shared SAP datapath widths and the word/address types built from them.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef logic [SAP_ADDR_W-1:0] sap_addr_t;
  typedef logic [SAP_DATA_W-1:0] sap_word_t;

endpackage : sap_pkg

// File: rtl/sap_memory.sv
// 16x8 program/data RAM: write on rising clk while write_enable is low, read combinationally.
// Latency: read 0 cycles; a write is visible on bus_out immediately after its capturing edge.
// Backpressure: none; a disabled output drives zeros so the CPU bus can be an OR of module outputs.
module sap_memory
  import sap_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP_ADDR_W,
  parameter int DATA_WIDTH = SAP_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  write_enable,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] bus_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Reset clears every word at once and takes priority over a pending write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!write_enable) begin
      mem_q[address] <= data;
    end
  end

  assign bus_out = enable ? '0 : mem_q[address];

endmodule : sap_memory

// File: tb/tb_sap_memory.sv
// Self-checking bench for sap_memory: directed scenarios plus random traffic against an array model.
module tb_sap_memory;
  import sap_pkg::*;

  logic      clk;
  logic      rst_n;
  sap_addr_t address;
  sap_word_t data;
  logic      write_enable;
  logic      enable;
  sap_word_t bus_out;

  int n_checks;
  int n_fail;

  sap_word_t model [16];

  sap_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .data         (data),
    .write_enable (write_enable),
    .enable       (enable),
    .bus_out      (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sap_word_t expected_bus(input logic en, input sap_addr_t a);
    return en ? 8'h00 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
  endtask

  // One-edge write, inputs changed on the falling edge so they are stable at the rising edge.
  task automatic do_write(input sap_addr_t a, input sap_word_t d);
    @(negedge clk);
    address      = a;
    data         = d;
    write_enable = 1'b0;
    @(posedge clk);
    #1;
    if (rst_n) model[a] = d;
    @(negedge clk);
    write_enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    write_enable = 1'b1;
    data         = 8'h00;
    address      = '0;
    model_clear();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      address = sap_addr_t'(i);
      #1;
      n_checks++;
      if (bus_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=00", i, bus_out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    do_write(4'h2, 8'hAA);
    do_write(4'h5, 8'hCC);
    enable  = 1'b0;
    address = 4'h2;
    #1;
    n_checks++;
    if (bus_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL write_read_a2 got=%h exp=aa", bus_out);
    end
    address = 4'h5;
    #1;
    n_checks++;
    if (bus_out !== 8'hCC) begin
      n_fail++;
      $display("FAIL write_read_a5 got=%h exp=cc", bus_out);
    end
  endtask

  task automatic test_gating();
    address = 4'h5;
    enable  = 1'b1;
    #1;
    n_checks++;
    if (bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL gate_off got=%h exp=00", bus_out);
    end
    enable = 1'b0;
    #1;
    n_checks++;
    if (bus_out !== 8'hCC) begin
      n_fail++;
      $display("FAIL gate_on got=%h exp=cc", bus_out);
    end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    write_enable = 1'b1;
    data         = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      address = sap_addr_t'(i);
      @(negedge clk);
    end
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address = sap_addr_t'(i);
      #1;
      n_checks++;
      if (bus_out !== model[i]) begin
        n_fail++;
        $display("FAIL no_write addr=%0d got=%h exp=%h", i, bus_out, model[i]);
      end
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    enable       = 1'b0;
    address      = 4'h2;
    data         = 8'h3C;
    write_enable = 1'b0;
    #1;
    n_checks++;
    if (bus_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL same_addr_before got=%h exp=aa", bus_out);
    end
    @(posedge clk);
    #1;
    model[2] = 8'h3C;
    n_checks++;
    if (bus_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL same_addr_after got=%h exp=3c", bus_out);
    end
    @(negedge clk);
    write_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    enable       = 1'b0;
    address      = 4'h3;
    data         = 8'h77;
    write_enable = 1'b0;
    #1;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      address = sap_addr_t'(i);
      #0.2;
      n_checks++;
      if (bus_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid addr=%0d got=%h exp=00", i, bus_out);
      end
    end
    address      = 4'h3;
    write_enable = 1'b1;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_nowrite got=%h exp=00", bus_out);
    end
  endtask

  task automatic test_random();
    sap_word_t exp;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      address      = sap_addr_t'($urandom_range(0, 15));
      data         = sap_word_t'($urandom);
      write_enable = ($urandom_range(0, 1) == 0);
      enable       = ($urandom_range(0, 3) == 0);
      #1;
      exp = expected_bus(enable, address);
      n_checks++;
      if (bus_out !== exp) begin
        n_fail++;
        $display("FAIL rand_pre n=%0d addr=%0d got=%h exp=%h", n, address, bus_out, exp);
      end
      @(posedge clk);
      #1;
      if (!write_enable) model[address] = data;
      exp = expected_bus(enable, address);
      n_checks++;
      if (bus_out !== exp) begin
        n_fail++;
        $display("FAIL rand_post n=%0d addr=%0d got=%h exp=%h", n, address, bus_out, exp);
      end
    end
    @(negedge clk);
    write_enable = 1'b1;
    enable       = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address = sap_addr_t'(i);
      #1;
      n_checks++;
      if (bus_out !== model[i]) begin
        n_fail++;
        $display("FAIL rand_final addr=%0d got=%h exp=%h", i, bus_out, model[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_gating();
    test_no_write();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sap_memory
